// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: FSM encodings, access sizes,
// requester identity and the IO address window.
package mem_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSB = 1'b1;

  // Byte count of an LSB access; the unused code 3 behaves as a word.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory responder for the fetch unit and the load/store buffer.
// Splits stores and assembles loads little-endian on the 8-bit RAM/IO bus.
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = mem_ctrl_pkg::IO_ADDR_HI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_rst,
  input  logic        if_send,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_val,
  input  logic        lsb_send,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  output logic        lsb_valid,
  output logic [31:0] lsb_val,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  import mem_ctrl_pkg::*;

  logic [1:0]  state;
  logic        owner;
  logic [31:0] base;
  logic [2:0]  len;
  logic [2:0]  cnt;
  logic [31:0] wdata;
  logic [31:0] rbuf;

  logic [2:0]  cnt_inc;
  logic [31:0] nxt_addr;
  logic [7:0]  nxt_byte;
  logic [31:0] rd_word;
  logic        io_hold;
  logic        req_io_hold;
  logic [31:0] req_addr;

  assign cnt_inc     = cnt + 3'd1;
  assign nxt_addr    = base + {29'd0, cnt_inc};
  assign nxt_byte    = wdata[{cnt_inc[1:0], 3'b000} +: 8];
  assign io_hold     = (base[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign req_io_hold = (lsb_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign req_addr    = lsb_send ? lsb_addr : if_addr;

  // The final byte of a read is merged straight from the bus, so the
  // completion edge needs no extra cycle.
  always_comb begin
    rd_word = rbuf;
    rd_word[{cnt[1:0], 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      base      <= '0;
      len       <= '0;
      cnt       <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      if_valid  <= 1'b0;
      lsb_valid <= 1'b0;
      if_val    <= '0;
      lsb_val   <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr    <= 1'b0;
    end else if (!rdy) begin
      mem_wr <= 1'b0;
    end else begin
      if_valid  <= 1'b0;
      lsb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!jump_rst && (lsb_send || if_send)) begin
            owner <= lsb_send ? OWN_LSB : OWN_IF;
            base  <= req_addr;
            len   <= lsb_send ? size_to_len(lsb_size) : 3'd4;
            wdata <= lsb_data;
            cnt   <= '0;
            rbuf  <= '0;
            mem_a <= req_addr;
            if (lsb_send && lsb_wr) begin
              state    <= ST_WRITE;
              mem_dout <= lsb_data[7:0];
              mem_wr   <= !req_io_hold;
            end else begin
              state  <= ST_READ;
              mem_wr <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (jump_rst) begin
            state  <= ST_IDLE;
            mem_wr <= 1'b0;
          end else begin
            rbuf <= rd_word;
            cnt  <= cnt_inc;
            if (cnt_inc < len) begin
              mem_a <= nxt_addr;
            end else begin
              state <= ST_DONE;
              if (owner == OWN_IF) begin
                if_valid <= 1'b1;
                if_val   <= rd_word;
              end else begin
                lsb_valid <= 1'b1;
                lsb_val   <= rd_word;
              end
            end
          end
        end
        ST_WRITE: begin
          // mem_wr high means the current byte was committed this cycle;
          // low means it is still pending (IO back-pressure or a rdy stall).
          if (mem_wr) begin
            cnt <= cnt_inc;
            if (cnt_inc < len) begin
              mem_a    <= nxt_addr;
              mem_dout <= nxt_byte;
              mem_wr   <= !io_hold;
            end else begin
              mem_wr    <= 1'b0;
              lsb_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end else begin
            mem_wr <= !io_hold;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
